// File: rtl/ht_cmd_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// ht_cmd_arbiter: round-robin sharing of the hash-table command port,
// with in-order result routing through a requester-ID FIFO. Rev 1.0
// ------------------------------------------------------------------
module ht_cmd_arbiter #(
  parameter int REQ_CNT      = 4,
  parameter int CMD_WIDTH    = 50,
  parameter int RES_WIDTH    = 52,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [REQ_CNT*CMD_WIDTH-1:0]     req_cmd_i,
  input  logic [REQ_CNT-1:0]               req_valid_i,
  output logic [REQ_CNT-1:0]               req_ready_o,
  output logic [CMD_WIDTH-1:0]             ht_cmd_o,
  output logic                             ht_cmd_valid_o,
  input  logic                             ht_cmd_ready_i,
  input  logic [RES_WIDTH-1:0]             ht_res_i,
  input  logic                             ht_res_valid_i,
  output logic                             ht_res_ready_o,
  output logic [RES_WIDTH-1:0]             req_res_o,
  output logic [REQ_CNT-1:0]               req_res_valid_o,
  input  logic [REQ_CNT-1:0]               req_res_ready_i,
  output logic [$clog2(MAX_INFLIGHT):0]    inflight_cnt_o,
  output logic                             unexpected_res_o
);

  localparam int ID_W  = $clog2(REQ_CNT);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [ID_W-1:0]  RR_RESET = ID_W'(REQ_CNT - 1);

  logic                 slot_full;
  logic [ID_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]     cnt;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [ID_W-1:0]      id_mem [MAX_INFLIGHT];
  logic                 unexpected;

  logic                 grant_found;
  logic [ID_W-1:0]      grant_id;
  logic                 grant;
  logic [CMD_WIDTH-1:0] grant_cmd;
  logic                 slot_free;
  logic                 can_accept;
  logic                 res_pop;
  logic                 fifo_empty;
  logic [ID_W-1:0]      head;
  logic [REQ_CNT-1:0]   head_sel_ready;
  logic                 head_ready;

  assign fifo_empty = (cnt == '0);
  assign head       = id_mem[rd_ptr];
  assign slot_free  = !slot_full || ht_cmd_ready_i;
  assign res_pop    = ht_res_valid_i && ht_res_ready_o;
  // A pop in the same cycle frees a FIFO entry, so a full FIFO can still accept.
  assign can_accept = slot_free && ((cnt < FULL_CNT) || res_pop);
  assign grant      = can_accept && grant_found;

  // Two-pass scan: indices above rr_ptr first, then wrap to those at or below it.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (!grant_found && req_valid_i[i] && (ID_W'(i) > rr_ptr)) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < REQ_CNT; i++) begin
      if (!grant_found && req_valid_i[i] && (ID_W'(i) <= rr_ptr)) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    grant_cmd = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_cmd = req_cmd_i[i*CMD_WIDTH +: CMD_WIDTH];
      end
    end
  end

  for (genvar g = 0; g < REQ_CNT; g++) begin : g_req
    assign req_ready_o[g]     = grant && (grant_id == ID_W'(g));
    assign req_res_valid_o[g] = ht_res_valid_i && !fifo_empty && (head == ID_W'(g));
    assign head_sel_ready[g]  = req_res_ready_i[g] && (head == ID_W'(g));
  end

  assign head_ready       = |head_sel_ready;
  assign ht_res_ready_o   = !fifo_empty && head_ready;
  assign req_res_o        = ht_res_i;
  assign ht_cmd_valid_o   = slot_full;
  assign inflight_cnt_o   = cnt;
  assign unexpected_res_o = unexpected;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_full <= 1'b0;
      ht_cmd_o  <= '0;
      rr_ptr    <= RR_RESET;
    end else if (grant) begin
      slot_full <= 1'b1;
      ht_cmd_o  <= grant_cmd;
      rr_ptr    <= grant_id;
    end else if (ht_cmd_ready_i) begin
      slot_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      unexpected <= 1'b0;
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (res_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({grant, res_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (ht_res_valid_i && fifo_empty) begin
        unexpected <= 1'b1;
      end
    end
  end

  // Storage is not reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      id_mem[wr_ptr] <= grant_id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ht_cmd_arbiter.sv
`default_nettype none
// tb_ht_cmd_arbiter: directed self-checking bench for ht_cmd_arbiter.
module tb_ht_cmd_arbiter;

  localparam int REQ_CNT      = 4;
  localparam int CMD_WIDTH    = 50;
  localparam int RES_WIDTH    = 52;
  localparam int MAX_INFLIGHT = 16;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [REQ_CNT*CMD_WIDTH-1:0] req_cmd;
  logic [REQ_CNT-1:0]           req_valid;
  logic [REQ_CNT-1:0]           req_ready;
  logic [CMD_WIDTH-1:0]         ht_cmd;
  logic                         ht_cmd_valid;
  logic                         ht_cmd_ready;
  logic [RES_WIDTH-1:0]         ht_res;
  logic                         ht_res_valid;
  logic                         ht_res_ready;
  logic [RES_WIDTH-1:0]         req_res;
  logic [REQ_CNT-1:0]           req_res_valid;
  logic [REQ_CNT-1:0]           req_res_ready;
  logic [4:0]                   inflight_cnt;
  logic                         unexpected_res;

  int checks   = 0;
  int failures = 0;
  int grant_cnt [REQ_CNT];

  always #5 clk = ~clk;

  ht_cmd_arbiter #(
    .REQ_CNT      (REQ_CNT),
    .CMD_WIDTH    (CMD_WIDTH),
    .RES_WIDTH    (RES_WIDTH),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_cmd_i        (req_cmd),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .ht_cmd_o         (ht_cmd),
    .ht_cmd_valid_o   (ht_cmd_valid),
    .ht_cmd_ready_i   (ht_cmd_ready),
    .ht_res_i         (ht_res),
    .ht_res_valid_i   (ht_res_valid),
    .ht_res_ready_o   (ht_res_ready),
    .req_res_o        (req_res),
    .req_res_valid_o  (req_res_valid),
    .req_res_ready_i  (req_res_ready),
    .inflight_cnt_o   (inflight_cnt),
    .unexpected_res_o (unexpected_res)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CMD_WIDTH-1:0] cmd_of(input int i);
    return {2'b01, 32'(32'h1000_0000 + i), 16'(16'hA000 + i)};
  endfunction

  function automatic logic [63:0] oh(input int i);
    logic [63:0] v;
    v = 64'd1;
    return v << i;
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    req_valid     = '0;
    ht_res_valid  = 1'b0;
    ht_res        = '0;
    ht_cmd_ready  = 1'b1;
    req_res_ready = '1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CMD_WIDTH-1:0] ins_cmd;
    logic [RES_WIDTH-1:0] res_b;

    for (int i = 0; i < REQ_CNT; i++) grant_cnt[i] = 0;
    req_cmd = '0;
    for (int i = 0; i < REQ_CNT; i++) req_cmd[i*CMD_WIDTH +: CMD_WIDTH] = cmd_of(i);

    // Reset state and unexpected-result handling
    do_reset();
    #1;
    chk("rst_cmd_valid", 64'(ht_cmd_valid), 64'd0);
    chk("rst_cmd", 64'(ht_cmd), 64'd0);
    chk("rst_inflight", 64'(inflight_cnt), 64'd0);
    chk("rst_unexpected", 64'(unexpected_res), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    ht_res_valid = 1'b1;
    ht_res       = 52'h5_5555;
    #1;
    chk("unexp_res_ready", 64'(ht_res_ready), 64'd0);
    chk("unexp_res_valid", 64'(req_res_valid), 64'd0);
    step();
    ht_res_valid = 1'b0;
    #1;
    chk("unexp_set", 64'(unexpected_res), 64'd1);
    step();
    chk("unexp_sticky", 64'(unexpected_res), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("unexp_cleared", 64'(unexpected_res), 64'd0);

    // Single INSERT from requester 2
    ins_cmd = {2'b01, 32'h0100_0000, 16'h1234};
    req_cmd[2*CMD_WIDTH +: CMD_WIDTH] = ins_cmd;
    req_valid = 4'b0100;
    #1;
    chk("single_grant", 64'(req_ready), 64'h4);
    chk("single_valid_c0", 64'(ht_cmd_valid), 64'd0);
    chk("single_cnt_c0", 64'(inflight_cnt), 64'd0);
    step();
    req_valid = '0;
    #1;
    chk("single_valid_c1", 64'(ht_cmd_valid), 64'd1);
    chk("single_cmd_c1", 64'(ht_cmd), 64'(ins_cmd));
    chk("single_cnt_c1", 64'(inflight_cnt), 64'd1);
    chk("single_no_regrant", 64'(req_ready), 64'd0);
    step();
    ht_res_valid = 1'b1;
    ht_res       = 52'hA_BCDE_F012;
    #1;
    chk("single_slot_clear", 64'(ht_cmd_valid), 64'd0);
    chk("single_res_route", 64'(req_res_valid), 64'h4);
    chk("single_res_ready", 64'(ht_res_ready), 64'd1);
    chk("single_res_data", 64'(req_res), 64'h0A_BCDE_F012);
    step();
    ht_res_valid = 1'b0;
    #1;
    chk("single_cnt_end", 64'(inflight_cnt), 64'd0);
    req_cmd[2*CMD_WIDTH +: CMD_WIDTH] = cmd_of(2);

    // All four requesters continuously valid, results returned immediately
    do_reset();
    req_valid = 4'b1111;
    for (int g = 0; g < 40; g++) begin
      ht_res_valid = (g > 0);
      ht_res       = 52'(g);
      #1;
      chk("rr_grant", 64'(req_ready), oh(g % 4));
      for (int i = 0; i < REQ_CNT; i++) if (req_ready[i]) grant_cnt[i]++;
      if (g > 0) begin
        chk("rr_cmd", 64'(ht_cmd), 64'(cmd_of((g - 1) % 4)));
        chk("rr_res_route", 64'(req_res_valid), oh((g - 1) % 4));
      end
      step();
    end
    req_valid    = '0;
    ht_res_valid = 1'b1;
    #1;
    chk("rr_idle_grant", 64'(req_ready), 64'd0);
    chk("rr_last_route", 64'(req_res_valid), 64'h8);
    chk("rr_last_cmd", 64'(ht_cmd), 64'(cmd_of(3)));
    step();
    ht_res_valid = 1'b0;
    #1;
    chk("rr_cnt_end", 64'(inflight_cnt), 64'd0);
    chk("rr_no_unexpected", 64'(unexpected_res), 64'd0);
    for (int i = 0; i < REQ_CNT; i++) chk("rr_grant_total", 64'(grant_cnt[i]), 64'd10);

    // Command-port backpressure with requesters 1 and 3
    do_reset();
    ht_cmd_ready = 1'b0;
    req_valid    = 4'b1010;
    #1;
    chk("bp_first_grant", 64'(req_ready), 64'h2);
    step();
    for (int c = 1; c < 5; c++) begin
      #1;
      chk("bp_no_grant", 64'(req_ready), 64'd0);
      chk("bp_slot_valid", 64'(ht_cmd_valid), 64'd1);
      chk("bp_slot_cmd", 64'(ht_cmd), 64'(cmd_of(1)));
      chk("bp_cnt", 64'(inflight_cnt), 64'd1);
      step();
    end
    ht_cmd_ready = 1'b1;
    #1;
    chk("bp_next_grant", 64'(req_ready), 64'h8);
    step();
    req_valid = '0;
    #1;
    chk("bp_cmd3", 64'(ht_cmd), 64'(cmd_of(3)));
    chk("bp_cmd3_valid", 64'(ht_cmd_valid), 64'd1);
    chk("bp_cnt2", 64'(inflight_cnt), 64'd2);

    // In-flight limit with requester 0 streaming, results withheld
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("lim_grant", 64'(req_ready), (c < 16) ? 64'd1 : 64'd0);
      chk("lim_cnt", 64'(inflight_cnt), (c < 16) ? 64'(c) : 64'd16);
      step();
    end
    ht_res_valid = 1'b1;
    ht_res       = 52'h777;
    #1;
    chk("lim_pop_ready", 64'(ht_res_ready), 64'd1);
    chk("lim_pop_route", 64'(req_res_valid), 64'd1);
    chk("lim_pop_grant", 64'(req_ready), 64'd1);
    step();
    ht_res_valid = 1'b0;
    #1;
    chk("lim_cnt_hold", 64'(inflight_cnt), 64'd16);
    chk("lim_full_again", 64'(req_ready), 64'd0);

    // Interleaved issue 0,2,1 with requester 2 stalling its result
    do_reset();
    req_valid = 4'b0001;
    #1;
    chk("il_grant0", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b0100;
    #1;
    chk("il_grant2", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b0010;
    #1;
    chk("il_grant1", 64'(req_ready), 64'h2);
    step();
    req_valid     = '0;
    req_res_ready = 4'b1011;
    ht_res_valid  = 1'b1;
    ht_res        = 52'hA;
    #1;
    chk("il_cnt3", 64'(inflight_cnt), 64'd3);
    chk("il_res0_route", 64'(req_res_valid), 64'h1);
    chk("il_res0_ready", 64'(ht_res_ready), 64'd1);
    step();
    res_b  = 52'hB_0B0B;
    ht_res = res_b;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("il_stall_route", 64'(req_res_valid), 64'h4);
      chk("il_stall_ready", 64'(ht_res_ready), 64'd0);
      step();
    end
    req_res_ready = 4'b1111;
    #1;
    chk("il_res2_route", 64'(req_res_valid), 64'h4);
    chk("il_res2_ready", 64'(ht_res_ready), 64'd1);
    chk("il_res2_data", 64'(req_res), 64'(res_b));
    step();
    ht_res = 52'hC;
    #1;
    chk("il_res1_route", 64'(req_res_valid), 64'h2);
    chk("il_res1_ready", 64'(ht_res_ready), 64'd1);
    step();
    ht_res_valid = 1'b0;
    #1;
    chk("il_cnt_end", 64'(inflight_cnt), 64'd0);
    chk("il_no_unexpected", 64'(unexpected_res), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ht_cmd_arbiter.md
Name: ht_cmd_arbiter

Overview:
- Shares the single hash-table command port among REQ_CNT independent requesters, using round-robin arbitration.
- Routes each result back to the requester that issued the matching command.
- Relies on hash_table_top returning results in command order. A requester-ID FIFO tracks commands in flight.
- Sits between the client logic and the hash_table_top ht_cmd_in / ht_res_out ports.

Parameters:
- REQ_CNT, 4, number of requesters (2..8).
- CMD_WIDTH, 50, packed ht_command_t width (opcode + key + value).
- RES_WIDTH, 52, packed result width.
- MAX_INFLIGHT, 16, ID FIFO depth; a power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_cmd_i  in  REQ_CNT*CMD_WIDTH  per-requester command; requester i occupies slice [i*CMD_WIDTH +: CMD_WIDTH].
- req_valid_i  in  REQ_CNT  per-requester command valid.
- req_ready_o  out  REQ_CNT  per-requester command accepted (one-hot or zero).
- ht_cmd_o  out  CMD_WIDTH  command to the hash table.
- ht_cmd_valid_o  out  1  command valid.
- ht_cmd_ready_i  in  1  hash table accepts the command.
- ht_res_i  in  RES_WIDTH  result from the hash table.
- ht_res_valid_i  in  1  result valid.
- ht_res_ready_o  out  1  result consumed.
- req_res_o  out  RES_WIDTH  result broadcast to all requesters (equals ht_res_i).
- req_res_valid_o  out  REQ_CNT  one-hot result valid for the owning requester.
- req_res_ready_i  in  REQ_CNT  per-requester result ready.
- inflight_cnt_o  out  $clog2(MAX_INFLIGHT)+1  current ID FIFO occupancy.
- unexpected_res_o  out  1  sticky flag: a result arrived while no command was outstanding.

Behaviour:
- Reset values: ht_cmd_valid_o=0, ht_cmd_o=0, inflight_cnt_o=0, unexpected_res_o=0, rr_ptr=REQ_CNT-1, ID FIFO empty.
- Command output slot is a single register (slot_full drives ht_cmd_valid_o).
- slot_free = !slot_full || ht_cmd_ready_i.
- can_accept = slot_free && (cnt < MAX_INFLIGHT || res_pop).
- res_pop = ht_res_valid_i && ht_res_ready_o.
- Grant (combinational):
  - If can_accept, select the first i with req_valid_i[i], searching rr_ptr+1, rr_ptr+2, … modulo REQ_CNT.
  - req_ready_o[i]=1 for that i only; otherwise req_ready_o=0.
- On a grant:
  - ht_cmd_o is loaded with that requester's command and slot_full=1, both on the next clock edge (1-cycle latency).
  - The grant ID is pushed into the ID FIFO.
  - rr_ptr takes the granted ID.
- With no grant: rr_ptr holds. If ht_cmd_ready_i was asserted, slot_full clears.
- Fairness: any continuously valid requester is granted within REQ_CNT grants.
- Result routing:
  - head = ID FIFO output.
  - req_res_valid_o[head] = ht_res_valid_i && !fifo_empty; all other bits are 0.
  - ht_res_ready_o = !fifo_empty && req_res_ready_i[head].
  - Pop the FIFO on res_pop.
  - A requester's backpressure stalls the whole result stream; this is intended because ordering must be preserved.
- Simultaneous push and pop:
  - cnt is unchanged.
  - Allowed at cnt==MAX_INFLIGHT; FIFO storage must support read-before-write at the same address.
- Empty FIFO with ht_res_valid_i=1:
  - ht_res_ready_o=0 (the result is not consumed).
  - unexpected_res_o is set and stays set until reset.
- inflight_cnt_o counts commands granted but whose results have not been popped. This includes the command sitting in the output slot.
- Reset mid-operation:
  - All state clears on the next edge. Outstanding IDs are discarded and the slot is dropped.
  - The hash table is reset concurrently, so no results return for those commands.
- FIFO pointers are $clog2(MAX_INFLIGHT) bits wide and wrap naturally.

Test Plan:
- Single requester 2 issues INSERT key 0x01000000 value 0x1234 at cycle 0 -> req_ready_o=4'b0100 in the same cycle; ht_cmd_valid_o=1 with that command at cycle 1; the returned result appears only on req_res_valid_o[2]; inflight_cnt_o goes 0→1→0.
- All 4 requesters hold valid continuously, ht_cmd_ready_i=1, results returned immediately -> grant order 0,1,2,3,0,1,…; after 40 grants each requester has exactly 10.
- ht_cmd_ready_i=0 for 5 cycles with requesters 1 and 3 valid -> exactly 1 grant (requester 1); the slot holds a stable command; no further req_ready_o until ready returns, then requester 3 is granted next.
- Results withheld, requester 0 streams 20 commands -> grants stop at inflight_cnt_o=16. Returning one result with req_res_ready_i[0]=1 allows a grant in that same cycle; the count stays at 16.
- Interleaved issue 0,2,1 with requester 2 holding req_res_ready_i=0 for 3 cycles -> the first result goes to 0; the second stalls (ht_res_ready_o=0) and then goes to 2; the third goes to 1.
- ht_res_valid_i=1 at reset-idle -> ht_res_ready_o=0 and unexpected_res_o=1 the next cycle, held until rst_i is asserted.
